// File: rtl/sha_miner_pkg.sv
// Shared definitions for the sha_miner UART front end: default work-unit
// size, the work-loader state type and a constant-folding clog2 helper.
package sha_miner_pkg;

  localparam int WORK_BYTES_DEFAULT = 44;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } loader_state_t;

  // Number of bits needed to encode the values 0 .. value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_work_loader.sv
// uart_work_loader: packs a burst of UART bytes, framed by the receiver's
// end-of-packet pulse, into one WORK_BYTES-wide work unit. The first byte
// received ends up in the MSB. Bursts that are too short or too long are
// rejected with a frame_err strobe.
// Optional build macro: UART_CHECKSUM_EN -- each burst carries one extra
// trailing check byte; the XOR of all bytes of the burst must be 8'h00.
module uart_work_loader
  import sha_miner_pkg::*;
#(
  parameter int WORK_BYTES = WORK_BYTES_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_ready,
  input  logic                    rx_eop,
  output logic [8*WORK_BYTES-1:0] work_data,
  output logic                    work_valid,
  output logic                    frame_err,
  output logic                    busy
);

`ifdef UART_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  localparam int PKT_LEN = WORK_BYTES + CHK_BYTES;
  localparam int SRW     = 8 * WORK_BYTES;
  // Wide enough to hold the saturation value PKT_LEN+1; this is
  // clog2(WORK_BYTES+2) without the check byte.
  localparam int CW      = clog2(PKT_LEN + 2);

  localparam logic [CW-1:0] WB_C      = CW'(WORK_BYTES);
  localparam logic [CW-1:0] PKT_LEN_C = CW'(PKT_LEN);
  localparam logic [CW-1:0] CNT_MAX_C = CW'(PKT_LEN + 1);

  loader_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SRW-1:0]  sr_q, sr_d;
  logic [SRW-1:0]  work_q, work_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            in_burst_s;
  logic            chk_ok_s;

`ifdef UART_CHECKSUM_EN
  logic [7:0]      acc_q, acc_d;
`endif

  // Next-state: apply the incoming byte first, then judge eop on the updated count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    work_d  = work_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef UART_CHECKSUM_EN
    acc_d   = acc_q;
`endif

    if (rx_ready) begin
      case (state_q)
        IDLE: begin
          sr_d    = {sr_q[SRW-9:0], rx_data};
          cnt_d   = {{(CW-1){1'b0}}, 1'b1};
          state_d = COLLECT;
`ifdef UART_CHECKSUM_EN
          acc_d   = rx_data;
`endif
        end
        COLLECT: begin
          // Bytes past WORK_BYTES (the check byte) are counted but not shifted.
          if (cnt_q < WB_C) begin
            sr_d = {sr_q[SRW-9:0], rx_data};
          end else begin
            sr_d = sr_q;
          end
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
`ifdef UART_CHECKSUM_EN
          acc_d = acc_q ^ rx_data;
`endif
          if (cnt_d == PKT_LEN_C) begin
            state_d = FULL;
          end else begin
            state_d = COLLECT;
          end
        end
        FULL: begin
          // Overlong burst: only the count moves, saturating one past PKT_LEN.
          if (cnt_q < CNT_MAX_C) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end

`ifdef UART_CHECKSUM_EN
    chk_ok_s = (acc_d == 8'h00);
`else
    chk_ok_s = 1'b1;
`endif

    // A lone eop while idle belongs to no burst and is ignored.
    in_burst_s = (state_q != IDLE) || rx_ready;

    if (rx_eop && in_burst_s) begin
      if ((cnt_d == PKT_LEN_C) && chk_ok_s) begin
        work_d  = sr_d;
        valid_d = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
      state_d = IDLE;
      cnt_d   = {CW{1'b0}};
`ifdef UART_CHECKSUM_EN
      acc_d   = 8'h00;
`endif
    end else begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered output strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      sr_q    <= {SRW{1'b0}};
      work_q  <= {SRW{1'b0}};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_CHECKSUM_EN
      acc_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      work_q  <= work_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
`ifdef UART_CHECKSUM_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign work_data  = work_q;
  assign work_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_work_loader.sv
// Directed bench for uart_work_loader with WORK_BYTES=4. A burst-level model
// (queue of bytes per burst, judged at eop) predicts every output each cycle;
// hand-computed literals pin the main scenarios. Honours UART_CHECKSUM_EN.
module tb_uart_work_loader;

  localparam int WB = 4;
`ifdef UART_CHECKSUM_EN
  localparam int PLEN = WB + 1;
`else
  localparam int PLEN = WB;
`endif

  logic          clk;
  logic          rst_n;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          rx_eop;
  logic [8*WB-1:0] work_data;
  logic          work_valid;
  logic          frame_err;
  logic          busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_work_loader #(.WORK_BYTES(WB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .rx_eop     (rx_eop),
    .work_data  (work_data),
    .work_valid (work_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]      burst[$];
  bit              in_burst  = 1'b0;
  logic [8*WB-1:0] exp_work  = '0;
  logic            exp_valid = 1'b0;
  logic            exp_err   = 1'b0;
  logic            exp_busy  = 1'b0;

  function automatic bit burst_ok();
    logic [7:0] x;
    if (burst.size() != PLEN) return 1'b0;
    x = 8'h00;
    foreach (burst[i]) x = x ^ burst[i];
`ifdef UART_CHECKSUM_EN
    return (x == 8'h00);
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst.delete();
      in_burst  = 1'b0;
      exp_work  = '0;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      exp_busy  = 1'b0;
    end else begin
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (rx_ready) begin
        burst.push_back(rx_data);
        in_burst = 1'b1;
      end
      if (rx_eop && in_burst) begin
        if (burst_ok()) begin
          for (int i = 0; i < WB; i++) exp_work[8*(WB-1-i) +: 8] = burst[i];
          exp_valid = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        burst.delete();
        in_burst = 1'b0;
      end
      exp_busy = in_burst;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_work_data",  work_data,  exp_work);
    chk("cyc_work_valid", {31'd0, work_valid}, {31'd0, exp_valid});
    chk("cyc_frame_err",  {31'd0, frame_err},  {31'd0, exp_err});
    chk("cyc_busy",       {31'd0, busy},       {31'd0, exp_busy});
  end

  // ---------------- stimulus helpers (entered and left at negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_ready = 1'b1; rx_eop = 1'b0;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_eop();
    rx_ready = 1'b0; rx_eop = 1'b1;
    @(negedge clk);
    rx_eop = 1'b0;
  endtask

  task automatic send_both(input logic [7:0] b);
    rx_data = b; rx_ready = 1'b1; rx_eop = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; rx_eop = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_work_data", work_data, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, work_valid}, 32'd0);

    // 1: nominal unit
    send_byte(8'h11); send_byte(8'h22);
    chk("t1_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h33); send_byte(8'h44);
`ifdef UART_CHECKSUM_EN
    send_byte(8'h44);
`endif
    send_eop();
    chk("t1_valid", {31'd0, work_valid}, 32'd1);
    chk("t1_err", {31'd0, frame_err}, 32'd0);
    chk("t1_data", work_data, 32'h11223344);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    idle(2);
    chk("t1_valid_drop", {31'd0, work_valid}, 32'd0);

    // 2: short burst
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    send_eop();
    chk("t2_err", {31'd0, frame_err}, 32'd1);
    chk("t2_valid", {31'd0, work_valid}, 32'd0);
    chk("t2_data_held", work_data, 32'h11223344);
    idle(2);

    // 3/4: five bytes
    for (int i = 1; i <= 4; i++) send_byte(i[7:0]);
`ifdef UART_CHECKSUM_EN
    send_byte(8'h04);
    send_eop();
    chk("t3_valid", {31'd0, work_valid}, 32'd1);
    chk("t3_data", work_data, 32'h01020304);
    idle(2);
    for (int i = 1; i <= 5; i++) send_byte(i[7:0]);
    send_eop();
    chk("t4_err", {31'd0, frame_err}, 32'd1);
    chk("t4_valid", {31'd0, work_valid}, 32'd0);
`else
    send_byte(8'h05);
    send_eop();
    chk("t3_err", {31'd0, frame_err}, 32'd1);
    chk("t3_valid", {31'd0, work_valid}, 32'd0);
    chk("t3_data_held", work_data, 32'h11223344);
`endif
    idle(2);

    // 5: reset mid-burst
    send_byte(8'h55); send_byte(8'h66);
    @(posedge clk); #2 rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_data", work_data, 32'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef UART_CHECKSUM_EN
    send_byte(8'h22);
`endif
    send_eop();
    chk("t5_valid", {31'd0, work_valid}, 32'd1);
    chk("t5_data", work_data, 32'hDEADBEEF);
    idle(2);

    // 6: last byte and eop together
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef UART_CHECKSUM_EN
    send_byte(8'h44);
`endif
    send_both(8'h44);
    chk("t6_valid", {31'd0, work_valid}, 32'd1);
    chk("t6_data", work_data, 32'h11223344);
    idle(2);

    // lone eop in IDLE
    send_eop();
    chk("lone_eop_valid", {31'd0, work_valid}, 32'd0);
    chk("lone_eop_err", {31'd0, frame_err}, 32'd0);
    chk("lone_eop_busy", {31'd0, busy}, 32'd0);
    idle(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
